uop_dispatch_buffer: RTL



---
 rtl/uop_dispatch_buffer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uop_dispatch_buffer.sv
// In-order decoded-uop buffer between decode and the issue queues, with sequence-ID tagging.
// Optional same-cycle empty-buffer bypass is enabled by defining UOP_DISPATCH_BYPASS_EN.

package uopc;
  typedef enum logic [3:0] {
    UOP_NOP  = 4'd0,  UOP_ADD = 4'd1,  UOP_SUB = 4'd2,  UOP_AND = 4'd3,
    UOP_OR   = 4'd4,  UOP_XOR = 4'd5,  UOP_SLL = 4'd6,  UOP_SRL = 4'd7,
    UOP_LD   = 4'd8,  UOP_ST  = 4'd9,  UOP_BEQ = 4'd10, UOP_JAL = 4'd11,
    UOP_JALR = 4'd12, UOP_LUI = 4'd13, UOP_MUL = 4'd14, UOP_DIV = 4'd15
  } micro_opcode_t;
endpackage

package iqt;
  typedef enum logic [1:0] {
    IQ_INT = 2'd0, IQ_MEM = 2'd1, IQ_FP = 2'd2, IQ_BRU = 2'd3
  } queue_type_t;
endpackage

package exut;
  typedef enum logic [2:0] {
    EXU_ALU = 3'd0, EXU_MUL = 3'd1, EXU_DIV = 3'd2, EXU_LSU = 3'd3,
    EXU_BRU = 3'd4, EXU_FPU = 3'd5, EXU_CSR = 3'd6, EXU_NONE = 3'd7
  } exe_unit_type_t;
endpackage

package immt;
  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3,
    IMM_J = 3'd4, IMM_Z = 3'd5, IMM_SH = 3'd6, IMM_NONE = 3'd7
  } imm_type_t;
endpackage

module uop_dispatch_buffer #(
  parameter int DEPTH  = 8,
  parameter int NUM_IQ = 4,
  parameter int ID_W   = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  uopc::micro_opcode_t          in_uopcode,
  input  iqt::queue_type_t             in_iq_type,
  input  exut::exe_unit_type_t         in_exu_type,
  input  immt::imm_type_t              in_imm_type,
  input  logic                         in_has_rd,
  input  logic                         in_has_rs1,
  input  logic                         in_has_rs2,
  input  logic                         in_is_br,
  input  logic                         in_is_jal,
  input  logic                         in_is_jalr,
  input  logic                         in_shadowable,
  input  logic                         in_under_shadow,
  input  logic [19:0]                  in_packed_imm,
  output logic                         out_valid,
  output uopc::micro_opcode_t          out_uopcode,
  output iqt::queue_type_t             out_iq_type,
  output exut::exe_unit_type_t         out_exu_type,
  output immt::imm_type_t              out_imm_type,
  output logic                         out_has_rd,
  output logic                         out_has_rs1,
  output logic                         out_has_rs2,
  output logic                         out_is_br,
  output logic                         out_is_jal,
  output logic                         out_is_jalr,
  output logic                         out_shadowable,
  output logic                         out_under_shadow,
  output logic [19:0]                  out_packed_imm,
  output logic [ID_W-1:0]              out_uop_id,
  input  logic [NUM_IQ-1:0]            iq_ready,
  output logic                         out_fire,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    uopc::micro_opcode_t  uopcode;
    iqt::queue_type_t     iq_type;
    exut::exe_unit_type_t exu_type;
    immt::imm_type_t      imm_type;
    logic                 has_rd;
    logic                 has_rs1;
    logic                 has_rs2;
    logic                 is_br;
    logic                 is_jal;
    logic                 is_jalr;
    logic                 shadowable;
    logic                 under_shadow;
    logic [19:0]          packed_imm;
    logic [ID_W-1:0]      id;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ID_W-1:0]    next_id_q, next_id_d;

  entry_t in_entry_s;
  entry_t out_entry_s;
  logic   full_s;
  logic   push_s;
  logic   bypass_s;
  logic   out_valid_s;
  logic   fire_s;
  logic   wr_s;
  logic   rd_s;

  // Ready of the issue queue selected by a type; out-of-range types select nothing.
  function automatic logic iq_sel(input logic [NUM_IQ-1:0] rdy, input iqt::queue_type_t t);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_IQ; i++) begin
      r = r | (rdy[i] & (32'(t) == 32'(i)));
    end
    return r;
  endfunction

  // Handshake, head selection (FIFO head or bypassed input) and dispatch decision.
  always_comb begin
    in_entry_s.uopcode      = in_uopcode;
    in_entry_s.iq_type      = in_iq_type;
    in_entry_s.exu_type     = in_exu_type;
    in_entry_s.imm_type     = in_imm_type;
    in_entry_s.has_rd       = in_has_rd;
    in_entry_s.has_rs1      = in_has_rs1;
    in_entry_s.has_rs2      = in_has_rs2;
    in_entry_s.is_br        = in_is_br;
    in_entry_s.is_jal       = in_is_jal;
    in_entry_s.is_jalr      = in_is_jalr;
    in_entry_s.shadowable   = in_shadowable;
    in_entry_s.under_shadow = in_under_shadow;
    in_entry_s.packed_imm   = in_packed_imm;
    in_entry_s.id           = next_id_q;

    full_s   = (count_q == CNT_W'(DEPTH));
    in_ready = !full_s && !flush;
    push_s   = in_valid && in_ready;
`ifdef UOP_DISPATCH_BYPASS_EN
    bypass_s = (count_q == CNT_W'(0)) && push_s && iq_sel(iq_ready, in_iq_type);
`else
    bypass_s = 1'b0;
`endif

    // Outputs are zeroed while empty so the ID reads 0 out of reset.
    if (bypass_s) begin
      out_valid_s = 1'b1;
      out_entry_s = in_entry_s;
    end else if (count_q != CNT_W'(0)) begin
      out_valid_s = 1'b1;
      out_entry_s = mem_q[head_q];
    end else begin
      out_valid_s = 1'b0;
      out_entry_s = '0;
    end

    fire_s = out_valid_s && iq_sel(iq_ready, out_entry_s.iq_type);
    wr_s   = push_s && !bypass_s;
    rd_s   = fire_s && !bypass_s;
  end

  // Next-state for storage, pointers, occupancy and sequence ID.
  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    next_id_d = next_id_q;
    if (flush) begin
      head_d  = PTR_W'(0);
      tail_d  = PTR_W'(0);
      count_d = CNT_W'(0);
    end else begin
      if (wr_s) begin
        mem_d[tail_q] = in_entry_s;
        tail_d        = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end
      if (rd_s) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      case ({wr_s, rd_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (push_s) begin
        next_id_d = next_id_q + ID_W'(1);
      end else begin
        next_id_d = next_id_q;
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= PTR_W'(0);
      tail_q    <= PTR_W'(0);
      count_q   <= CNT_W'(0);
      next_id_q <= ID_W'(0);
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      next_id_q <= next_id_d;
    end
  end

  // Payload storage needs no reset; validity comes from count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid        = out_valid_s;
  assign out_fire         = fire_s;
  assign out_uopcode      = out_entry_s.uopcode;
  assign out_iq_type      = out_entry_s.iq_type;
  assign out_exu_type     = out_entry_s.exu_type;
  assign out_imm_type     = out_entry_s.imm_type;
  assign out_has_rd       = out_entry_s.has_rd;
  assign out_has_rs1      = out_entry_s.has_rs1;
  assign out_has_rs2      = out_entry_s.has_rs2;
  assign out_is_br        = out_entry_s.is_br;
  assign out_is_jal       = out_entry_s.is_jal;
  assign out_is_jalr      = out_entry_s.is_jalr;
  assign out_shadowable   = out_entry_s.shadowable;
  assign out_under_shadow = out_entry_s.under_shadow;
  assign out_packed_imm   = out_entry_s.packed_imm;
  assign out_uop_id       = out_entry_s.id;
  assign count            = count_q;

endmodule
